dsi_tx_arbiter: RTL and testbench

Arbitrates the single DSI host TX packet interface between two requesters: the command/panel-init path (packet assembler fed from the init FIFO) and the video packet path. It replaces static select-line muxing with a per-packet req/ack/active sequencer and runs entirely in the TxByteClkHS domain. Video has priority, a starvation limit guarantees command service, and a timeout recovers from a host that never acknowledges or never goes active.

---
 rtl/dsi_tx_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_dsi_tx_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsi_tx_arbiter.sv
// Per-packet arbiter sharing the DSI host TX header/payload interface between the
// command path and the video path. Video has priority, with a starvation limit and a request timeout.
module dsi_tx_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned TIMEOUT      = 4095
) (
  input  logic        TxByteClkHS,
  input  logic        rstn,
  input  logic        cmd_req,
  input  logic        vid_req,
  input  logic [1:0]  cmd_vc,
  input  logic [1:0]  vid_vc,
  input  logic [5:0]  cmd_data_type,
  input  logic [5:0]  vid_data_type,
  input  logic [15:0] cmd_byte_count,
  input  logic [15:0] vid_byte_count,
  input  logic        cmd_hs_mode,
  input  logic        vid_hs_mode,
  input  logic [31:0] cmd_payload,
  input  logic [31:0] vid_payload,
  output logic        cmd_ack,
  output logic        vid_ack,
  output logic        cmd_payload_en,
  output logic        vid_payload_en,
  output logic        cmd_payload_en_last,
  output logic        vid_payload_en_last,
  output logic        cmd_done,
  output logic        vid_done,
  output logic        cmd_err,
  output logic        vid_err,
  output logic [1:0]  host_tx_cmd_vc,
  output logic [5:0]  host_tx_cmd_data_type,
  output logic [15:0] host_tx_cmd_byte_count,
  output logic        host_tx_hs_mode,
  output logic        host_tx_cmd_req,
  input  logic        host_tx_cmd_ack,
  input  logic        host_tx_active,
  input  logic        host_tx_payload_en,
  input  logic        host_tx_payload_en_last,
  output logic [31:0] host_tx_payload,
  output logic        busy,
  output logic        grant_vid
);

  localparam logic [3:0]  StarveMax  = 4'(STARVE_LIMIT);
  localparam logic [11:0] TimeoutMax = 12'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StReq, StWaitAct, StActive, StDone} state_e;

  state_e      state_q, state_d;
  logic [11:0] timer_q, timer_d;
  logic [3:0]  starve_q, starve_d;
  logic        grant_vid_q, grant_vid_d;
  logic [1:0]  vc_q, vc_d;
  logic [5:0]  dt_q, dt_d;
  logic [15:0] cnt_q, cnt_d;
  logic        hs_q, hs_d;
  logic        cmd_ack_q, cmd_ack_d, vid_ack_q, vid_ack_d;
  logic        cmd_done_q, cmd_done_d, vid_done_q, vid_done_d;
  logic        cmd_err_q, cmd_err_d, vid_err_q, vid_err_d;
  logic        pick_vid;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    starve_d    = starve_q;
    grant_vid_d = grant_vid_q;
    vc_d        = vc_q;
    dt_d        = dt_q;
    cnt_d       = cnt_q;
    hs_d        = hs_q;
    cmd_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    cmd_done_d  = 1'b0;
    vid_done_d  = 1'b0;
    cmd_err_d   = 1'b0;
    vid_err_d   = 1'b0;
    pick_vid    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_req || vid_req) begin
          pick_vid    = vid_req && !(cmd_req && (starve_q >= StarveMax));
          grant_vid_d = pick_vid;
          vc_d        = pick_vid ? vid_vc : cmd_vc;
          dt_d        = pick_vid ? vid_data_type : cmd_data_type;
          cnt_d       = pick_vid ? vid_byte_count : cmd_byte_count;
          hs_d        = pick_vid ? vid_hs_mode : cmd_hs_mode;
          timer_d     = '0;
          // Only video wins taken over a waiting command count toward starvation.
          if (pick_vid && cmd_req) begin
            starve_d = (starve_q >= StarveMax) ? starve_q : starve_q + 4'd1;
          end else begin
            starve_d = '0;
          end
          state_d = StReq;
        end
      end
      StReq: begin
        if (host_tx_cmd_ack) begin
          cmd_ack_d = !grant_vid_q;
          vid_ack_d = grant_vid_q;
          timer_d   = '0;
          state_d   = host_tx_active ? StActive : StWaitAct;
        end else if (timer_q == TimeoutMax) begin
          cmd_err_d = !grant_vid_q;
          vid_err_d = grant_vid_q;
          state_d   = StIdle;
        end else begin
          timer_d = timer_q + 12'd1;
        end
      end
      StWaitAct: begin
        if (host_tx_active) begin
          state_d = StActive;
        end else if (timer_q == TimeoutMax) begin
          cmd_err_d = !grant_vid_q;
          vid_err_d = grant_vid_q;
          state_d   = StIdle;
        end else begin
          timer_d = timer_q + 12'd1;
        end
      end
      StActive: begin
        if (!host_tx_active) state_d = StDone;
      end
      StDone: begin
        cmd_done_d = !grant_vid_q;
        vid_done_d = grant_vid_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge TxByteClkHS) begin
    if (!rstn) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      starve_q    <= '0;
      grant_vid_q <= 1'b0;
      vc_q        <= '0;
      dt_q        <= '0;
      cnt_q       <= '0;
      hs_q        <= 1'b0;
      cmd_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      cmd_done_q  <= 1'b0;
      vid_done_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      vid_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      starve_q    <= starve_d;
      grant_vid_q <= grant_vid_d;
      vc_q        <= vc_d;
      dt_q        <= dt_d;
      cnt_q       <= cnt_d;
      hs_q        <= hs_d;
      cmd_ack_q   <= cmd_ack_d;
      vid_ack_q   <= vid_ack_d;
      cmd_done_q  <= cmd_done_d;
      vid_done_q  <= vid_done_d;
      cmd_err_q   <= cmd_err_d;
      vid_err_q   <= vid_err_d;
    end
  end

  assign busy                   = (state_q != StIdle);
  assign host_tx_cmd_req        = (state_q == StReq);
  assign grant_vid              = grant_vid_q;
  assign host_tx_cmd_vc         = vc_q;
  assign host_tx_cmd_data_type  = dt_q;
  assign host_tx_cmd_byte_count = cnt_q;
  assign host_tx_hs_mode        = hs_q;
  assign cmd_ack                = cmd_ack_q;
  assign vid_ack                = vid_ack_q;
  assign cmd_done               = cmd_done_q;
  assign vid_done               = vid_done_q;
  assign cmd_err                = cmd_err_q;
  assign vid_err                = vid_err_q;

  // Strobes only reach the granted side while a packet is in flight.
  assign host_tx_payload     = grant_vid_q ? vid_payload : cmd_payload;
  assign cmd_payload_en      = busy && !grant_vid_q && host_tx_payload_en;
  assign vid_payload_en      = busy && grant_vid_q && host_tx_payload_en;
  assign cmd_payload_en_last = busy && !grant_vid_q && host_tx_payload_en_last;
  assign vid_payload_en_last = busy && grant_vid_q && host_tx_payload_en_last;

endmodule

// File: tb/tb_dsi_tx_arbiter.sv
// Randomized bench for dsi_tx_arbiter: acts as both requesters and the host, and
// predicts grants, header, routing, pulses and timeouts from a packet-level model.
module tb_dsi_tx_arbiter;

  localparam int Starve = 8;
  localparam int Tmo    = 15;

  logic        TxByteClkHS = 1'b0;
  logic        rstn;
  logic        cmd_req, vid_req;
  logic [1:0]  cmd_vc, vid_vc;
  logic [5:0]  cmd_data_type, vid_data_type;
  logic [15:0] cmd_byte_count, vid_byte_count;
  logic        cmd_hs_mode, vid_hs_mode;
  logic [31:0] cmd_payload, vid_payload;
  logic        cmd_ack, vid_ack;
  logic        cmd_payload_en, vid_payload_en, cmd_payload_en_last, vid_payload_en_last;
  logic        cmd_done, vid_done, cmd_err, vid_err;
  logic [1:0]  host_tx_cmd_vc;
  logic [5:0]  host_tx_cmd_data_type;
  logic [15:0] host_tx_cmd_byte_count;
  logic        host_tx_hs_mode, host_tx_cmd_req;
  logic        host_tx_cmd_ack, host_tx_active, host_tx_payload_en, host_tx_payload_en_last;
  logic [31:0] host_tx_payload;
  logic        busy, grant_vid;

  dsi_tx_arbiter #(.STARVE_LIMIT(Starve), .TIMEOUT(Tmo)) dut (
    .TxByteClkHS(TxByteClkHS), .rstn(rstn),
    .cmd_req(cmd_req), .vid_req(vid_req),
    .cmd_vc(cmd_vc), .vid_vc(vid_vc),
    .cmd_data_type(cmd_data_type), .vid_data_type(vid_data_type),
    .cmd_byte_count(cmd_byte_count), .vid_byte_count(vid_byte_count),
    .cmd_hs_mode(cmd_hs_mode), .vid_hs_mode(vid_hs_mode),
    .cmd_payload(cmd_payload), .vid_payload(vid_payload),
    .cmd_ack(cmd_ack), .vid_ack(vid_ack),
    .cmd_payload_en(cmd_payload_en), .vid_payload_en(vid_payload_en),
    .cmd_payload_en_last(cmd_payload_en_last), .vid_payload_en_last(vid_payload_en_last),
    .cmd_done(cmd_done), .vid_done(vid_done), .cmd_err(cmd_err), .vid_err(vid_err),
    .host_tx_cmd_vc(host_tx_cmd_vc), .host_tx_cmd_data_type(host_tx_cmd_data_type),
    .host_tx_cmd_byte_count(host_tx_cmd_byte_count), .host_tx_hs_mode(host_tx_hs_mode),
    .host_tx_cmd_req(host_tx_cmd_req), .host_tx_cmd_ack(host_tx_cmd_ack),
    .host_tx_active(host_tx_active), .host_tx_payload_en(host_tx_payload_en),
    .host_tx_payload_en_last(host_tx_payload_en_last), .host_tx_payload(host_tx_payload),
    .busy(busy), .grant_vid(grant_vid)
  );

  always #5 TxByteClkHS = ~TxByteClkHS;

  int total = 0;
  int bad   = 0;
  int starve_m;
  bit cmd_pend, vid_pend;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge TxByteClkHS);
    #1;
  endtask

  // Every output except the payload mux, which follows its inputs by definition.
  function automatic logic [63:0] all_outs();
    return {26'd0, cmd_ack, vid_ack, cmd_payload_en, vid_payload_en, cmd_payload_en_last,
            vid_payload_en_last, cmd_done, vid_done, cmd_err, vid_err, host_tx_cmd_vc,
            host_tx_cmd_data_type, host_tx_cmd_byte_count, host_tx_hs_mode, host_tx_cmd_req,
            busy, grant_vid};
  endfunction

  // Packet-level arbitration rule: video first unless command has waited STARVE grants.
  function automatic bit model_grant();
    bit pv;
    pv = vid_pend && !(cmd_pend && starve_m >= Starve);
    if (pv && cmd_pend) starve_m = (starve_m + 1 > Starve) ? Starve : starve_m + 1;
    else starve_m = 0;
    return pv;
  endfunction

  task automatic raise(input bit side_vid);
    if (side_vid && !vid_pend) begin
      vid_pend = 1'b1;
      vid_vc = 2'($urandom); vid_data_type = 6'($urandom);
      vid_byte_count = 16'($urandom); vid_hs_mode = 1'($urandom);
    end else if (!side_vid && !cmd_pend) begin
      cmd_pend = 1'b1;
      cmd_vc = 2'($urandom); cmd_data_type = 6'($urandom);
      cmd_byte_count = 16'($urandom); cmd_hs_mode = 1'($urandom);
    end
  endtask

  // Entered one cycle before the DUT's IDLE sampling edge.
  task automatic do_packet(input bit tmo, input int ack_dly, input int act_len,
                           input bit same, output bit gv);
    bit          ev;
    int          n;
    logic [24:0] hexp;
    cmd_req = cmd_pend;
    vid_req = vid_pend;
    ev      = model_grant();
    hexp    = ev ? {vid_vc, vid_data_type, vid_byte_count, vid_hs_mode}
                 : {cmd_vc, cmd_data_type, cmd_byte_count, cmd_hs_mode};
    cyc();
    gv = grant_vid;
    check_eq("grant_vid", grant_vid, ev);
    check_eq("req_after_grant", host_tx_cmd_req, 1'b1);
    check_eq("header", {host_tx_cmd_vc, host_tx_cmd_data_type, host_tx_cmd_byte_count,
                        host_tx_hs_mode}, hexp);
    check_eq("pulses_low", {cmd_done, vid_done, cmd_err, vid_err, cmd_ack, vid_ack}, 6'd0);
    if (ev) vid_pend = 1'b0; else cmd_pend = 1'b0;
    if (tmo) begin
      n = 0;
      while (host_tx_cmd_req && n < 64) begin
        n++;
        cyc();
      end
      cmd_req = 1'b0;
      vid_req = 1'b0;
      check_eq("tmo_req_cycles", n, Tmo + 1);
      check_eq("tmo_err", {cmd_err, vid_err}, ev ? 2'b01 : 2'b10);
      check_eq("tmo_no_ack", {cmd_ack, vid_ack}, 2'b00);
      cyc();
      check_eq("tmo_idle", {busy, cmd_err, vid_err}, 3'b000);
      return;
    end
    repeat (ack_dly) begin
      cyc();
      check_eq("req_hold", host_tx_cmd_req, 1'b1);
    end
    host_tx_cmd_ack = 1'b1;
    if (same) host_tx_active = 1'b1;
    cyc();
    host_tx_cmd_ack = 1'b0;
    cmd_req = 1'b0;
    vid_req = 1'b0;
    check_eq("ack_pulse", {cmd_ack, vid_ack}, ev ? 2'b01 : 2'b10);
    check_eq("req_drop", host_tx_cmd_req, 1'b0);
    if (!same) begin
      repeat ($urandom_range(4)) cyc();
      host_tx_active = 1'b1;
    end
    cyc();
    check_eq("ack_one_cycle", {cmd_ack, vid_ack}, 2'b00);
    for (int i = 0; i < act_len; i++) begin
      host_tx_payload_en      = 1'($urandom);
      host_tx_payload_en_last = host_tx_payload_en && (i == act_len - 1);
      cmd_payload = $urandom;
      vid_payload = $urandom;
      #1;
      check_eq("payload", host_tx_payload, ev ? vid_payload : cmd_payload);
      check_eq("strobes", {cmd_payload_en, cmd_payload_en_last, vid_payload_en,
                           vid_payload_en_last},
               ev ? {2'b00, host_tx_payload_en, host_tx_payload_en_last}
                  : {host_tx_payload_en, host_tx_payload_en_last, 2'b00});
      cyc();
    end
    host_tx_payload_en      = 1'b0;
    host_tx_payload_en_last = 1'b0;
    host_tx_active          = 1'b0;
    cyc();
    check_eq("done_wait", {busy, cmd_done, vid_done}, 3'b100);
    cyc();
    check_eq("done_pulse", {busy, cmd_done, vid_done}, ev ? 3'b001 : 3'b010);
  endtask

  initial begin
    bit gv;
    rstn = 1'b0;
    cmd_req = 0; vid_req = 0;
    cmd_vc = 0; vid_vc = 0; cmd_data_type = 0; vid_data_type = 0;
    cmd_byte_count = 0; vid_byte_count = 0; cmd_hs_mode = 0; vid_hs_mode = 0;
    cmd_payload = 0; vid_payload = 0;
    host_tx_cmd_ack = 0; host_tx_active = 0; host_tx_payload_en = 0;
    host_tx_payload_en_last = 0;
    starve_m = 0; cmd_pend = 0; vid_pend = 0;
    cyc();
    cyc();
    check_eq("reset_outputs", all_outs(), 64'd0);
    rstn = 1'b1;
    cyc();

    // Directed video packet with a long active phase.
    vid_pend = 1'b1;
    vid_vc = 2'd0; vid_data_type = 6'h3E; vid_byte_count = 16'd5760; vid_hs_mode = 1'b1;
    do_packet(1'b0, 3, 200, 1'b0, gv);

    // Both requesters held: expect 8 video grants then one command grant.
    for (int k = 0; k < 18; k++) begin
      raise(1'b1);
      raise(1'b0);
      do_packet(1'b0, $urandom_range(2), 2, 1'b0, gv);
      check_eq("burst_order", gv, (k % 9) != 8);
    end

    // Short command write with payload fetch.
    cmd_pend = 1'b1;
    cmd_vc = 2'd1; cmd_data_type = 6'h29; cmd_byte_count = 16'd4; cmd_hs_mode = 1'b0;
    do_packet(1'b0, 1, 1, 1'b0, gv);

    // Host never acks, then a video packet must still be served.
    raise(1'b0);
    do_packet(1'b1, 0, 0, 1'b0, gv);
    raise(1'b1);
    do_packet(1'b0, 2, 3, 1'b0, gv);

    // ack and active together skip WAIT_ACT.
    raise(1'b1);
    do_packet(1'b0, 1, 3, 1'b1, gv);

    // Reset while ACTIVE.
    raise(1'b1);
    vid_req = 1'b1;
    gv = model_grant();
    vid_pend = 1'b0;
    cyc();
    check_eq("rst_pre_grant", grant_vid, 1'b1);
    host_tx_cmd_ack = 1'b1;
    host_tx_active  = 1'b1;
    cyc();
    host_tx_cmd_ack    = 1'b0;
    vid_req            = 1'b0;
    host_tx_payload_en = 1'b1;
    cyc();
    check_eq("rst_pre_active", {busy, vid_payload_en}, 2'b11);
    rstn = 1'b0;
    cyc();
    check_eq("reset_mid_packet", all_outs(), 64'd0);
    rstn = 1'b1;
    host_tx_active     = 1'b0;
    host_tx_payload_en = 1'b0;
    starve_m = 0;
    cyc();
    check_eq("post_reset_idle", {busy, cmd_done, vid_done, cmd_err, vid_err}, 5'd0);
    raise(1'b1);
    do_packet(1'b0, 1, 2, 1'b0, gv);

    // Random traffic.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(2) != 0) raise(1'b1);
      if ($urandom_range(2) != 0) raise(1'b0);
      if (!cmd_pend && !vid_pend) raise(1'($urandom));
      do_packet($urandom_range(7) == 0, $urandom_range(4), $urandom_range(8, 1),
                $urandom_range(3) == 0, gv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
